// File: rtl/joust2_rom_loader.sv
// Joust 2 ROM loader: decodes the HPS ioctl byte stream into program/sound/graphics RAMs,
// then hands the shared RAM port to the williams2 core and releases its reset after a settle delay.
module joust2_rom_loader #(
  parameter logic [16:0] PROG_TOP    = 17'h1FFFF,
  parameter logic [24:0] SND_BASE    = 25'h20000,
  parameter logic [24:0] GFX_BASE    = 25'h30000,
  parameter int          HOLD_CYCLES = 16,
  parameter logic [7:0]  ROM_INDEX   = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic [16:0] rom_addr,
  input  logic        rom_rd,
  output logic [7:0]  rom_do,
  output logic        prog_we,
  output logic        snd_we,
  output logic        gfx_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  prog_q,
  output logic        core_reset,
  output logic        load_done,
  output logic [15:0] checksum,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, RUN} state_t;

  state_t      state, state_nx;
  logic [24:0] lat_addr;
  logic [7:0]  lat_data;
  logic [15:0] hold_cnt;
  logic        dl_q, rd_q;
  logic        idx_ok, start, accept;
  logic        in_prog, in_snd, in_gfx, in_any;
  logic [16:0] snd_off, gfx_off;

  assign idx_ok = (ioctl_index == ROM_INDEX);
  // From IDLE a download is taken on level; from RUN only on a fresh rising edge.
  assign start  = ioctl_download && idx_ok &&
                  ((state == IDLE) || ((state == RUN) && !dl_q));
  assign accept = (state == LOAD) && ioctl_wr && idx_ok;

  assign in_prog = (lat_addr <= {8'd0, PROG_TOP});
  assign in_snd  = !in_prog && (lat_addr >= SND_BASE) && (lat_addr < SND_BASE + 25'h10000);
  assign in_gfx  = !in_prog && !in_snd &&
                   (lat_addr >= GFX_BASE) && (lat_addr < GFX_BASE + 25'h0C000);
  assign in_any  = in_prog || in_snd || in_gfx;
  assign snd_off = lat_addr[16:0] - SND_BASE[16:0];
  assign gfx_off = lat_addr[16:0] - GFX_BASE[16:0];

  assign prog_we    = (state == WRITE) && in_prog;
  assign snd_we     = (state == WRITE) && in_snd;
  assign gfx_we     = (state == WRITE) && in_gfx;
  assign mem_din    = lat_data;
  assign ioctl_wait = (state == WRITE);
  assign core_reset = (state != RUN) || start;
  assign load_done  = (state == RUN) && !start;

  always_comb begin
    mem_addr = lat_addr[16:0];
    if (state == RUN)  mem_addr = rom_addr;
    else if (in_snd)   mem_addr = snd_off;
    else if (in_gfx)   mem_addr = gfx_off;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (accept) state_nx = WRITE;
             else if (!ioctl_download) state_nx = HOLD;
      WRITE: state_nx = ioctl_download ? LOAD : HOLD;
      HOLD:  if (hold_cnt == 16'd0) state_nx = RUN;
      RUN:   if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      hold_cnt <= '0;
      dl_q     <= 1'b0;
      rd_q     <= 1'b0;
      checksum <= '0;
      overflow <= 1'b0;
      rom_do   <= '0;
    end else begin
      state <= state_nx;
      dl_q  <= ioctl_download;
      rd_q  <= rom_rd;
      if (accept) begin
        lat_addr <= ioctl_addr;
        lat_data <= ioctl_dout;
      end
      if (state_nx == HOLD && state != HOLD) hold_cnt <= 16'(HOLD_CYCLES - 1);
      else if (state == HOLD && hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
      if (start) begin
        checksum <= '0;
        overflow <= 1'b0;
      end else if (state == WRITE) begin
        if (in_any) checksum <= checksum + {8'd0, lat_data};
        else        overflow <= 1'b1;
      end
      // RAM has one cycle of latency; register its output for the core.
      if (state == RUN && rd_q) rom_do <= prog_q;
    end
  end

endmodule

// File: doc/joust2_rom_loader.md
# joust2_rom_loader

Upstream ROM-loading stage for the Joust 2 (williams2) core. Receives the HPS ioctl download byte stream, decodes it into the program, sound and graphics ROM regions, and writes it into single-port ROM RAMs. After download it hands each RAM's port to the williams2 core for reads, and holds the core in reset until the image is loaded and settled. Also reports load completion, a running checksum, and an overflow flag.

## Interface
Parameters:
- PROG_TOP, 17'h1FFFF: last byte of program region (ioctl 0x00000..PROG_TOP, core rom_addr space)
- SND_BASE, 25'h20000: first byte of sound region (64 KiB)
- GFX_BASE, 25'h30000: first byte of graphics region (48 KiB, ends GFX_BASE+0xBFFF)
- HOLD_CYCLES, 16: clk_sys cycles core_reset stays high after download ends
- ROM_INDEX, 8'd0: ioctl_index accepted; other indices ignored

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_dout valid
- ioctl_addr  in  25  byte address in image
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  image index
- ioctl_wait  out  1  back-pressure to HPS; high while a byte is pending
- rom_addr  in  17  core program-ROM read address
- rom_rd  in  1  core read strobe
- rom_do  out  8  program-ROM read data to core
- prog_we / snd_we / gfx_we  out  1 each  RAM write enables
- mem_addr  out  17  shared RAM address (loader address while loading, else rom_addr)
- mem_din  out  8  RAM write data
- prog_q  in  8  program RAM read data (1-cycle RAM latency)
- core_reset  out  1  reset to williams2
- load_done  out  1  high once a complete download has finished
- checksum  out  16  sum mod 2^16 of all accepted bytes
- overflow  out  1  sticky: byte addressed outside all regions

## Operation
- States: IDLE, LOAD, WRITE, HOLD, RUN.
- Reset: state IDLE; core_reset=1, load_done=0, ioctl_wait=0, all *_we=0, checksum=0, overflow=0, rom_do=0, mem_addr=0, mem_din=0.
- IDLE: core_reset=1. ioctl_download=1 with ioctl_index==ROM_INDEX -> LOAD, checksum cleared, overflow cleared, load_done cleared.
- LOAD: on ioctl_wr, latch addr/data, raise ioctl_wait, -> WRITE. ioctl_download falling with no pending byte -> HOLD.
- WRITE (exactly 1 cycle): decode latched address:
  - addr<=PROG_TOP -> prog_we, mem_addr=addr[16:0]
  - SND_BASE<=addr<SND_BASE+0x10000 -> snd_we, mem_addr=addr-SND_BASE
  - GFX_BASE<=addr<GFX_BASE+0xC000 -> gfx_we, mem_addr=addr-GFX_BASE
  - otherwise: no write, overflow<=1, checksum not updated
  - Accepted byte: checksum<=checksum+data (16-bit wrap).
  - Next cycle: drop ioctl_wait, return to LOAD (or to HOLD if ioctl_download already low).
- HOLD: counter from HOLD_CYCLES-1 to 0; at 0 -> RUN.
- RUN: core_reset=0, load_done=1. mem_addr follows rom_addr; rom_do<=prog_q registered. A new download (ioctl_download rising, matching index) -> LOAD, core_reset=1 asserted that same cycle, load_done=0.
- Mismatched ioctl_index during ioctl_download: stay in current state; ioctl_wr ignored, ioctl_wait stays 0.
- Exactly one *_we high in any cycle, only in WRITE.

## Timing
- Byte acceptance: ioctl_wr at cycle N -> ioctl_wait high at N+1, *_we high at N+1, ioctl_wait low at N+2. One byte per 2 cycles max; an ioctl_wr while ioctl_wait=1 is a protocol violation and is dropped.
- Core read latency in RUN: rom_addr at cycle N -> RAM addr N, prog_q N+1, rom_do valid N+2.
- ioctl_download fall -> core_reset deasserts after HOLD_CYCLES+1 cycles (HOLD entry + count).
- Async reset mid-download: immediate return to IDLE, outputs to reset values; partially written RAM contents undefined; load_done=0 until a full new download.

## Test plan
- Program load: index 0, bytes 0x00..0xFF at addr 0..255 -> prog_we at 256 addresses, mem_din matches, checksum=0x7F80, load_done=1 HOLD_CYCLES+1 cycles after download falls, overflow=0.
- Region decode: bytes at 0x1FFFF, 0x20000, 0x2FFFF, 0x30000, 0x3BFFF -> prog_we@0x1FFFF, snd_we@0x0000, snd_we@0xFFFF, gfx_we@0x0000, gfx_we@0xBFFF; no other *_we.
- Out of range: byte 0x55 at 0x3C000 -> no *_we, overflow=1, checksum unchanged.
- Wrong index: ioctl_index=1 download with 10 writes -> no *_we, ioctl_wait=0, state and core_reset unchanged.
- Core read: after load, rom_addr=0x0005 with rom_rd -> rom_do=0x05 two cycles later; core_reset=0.
- Reset mid-download: assert reset after 3 bytes -> core_reset=1, load_done=0, checksum=0 asynchronously; then clean full load completes normally.
